// File: rtl/fifo_status_monitor.sv
// Purpose : tracks occupancy of five FIFOs (MF, VC0, VC1, D0, D1) and reports empty/almost/error flags.
// Latency : flags are decodes of registered counts, so they show a push/pop the cycle after its sampling edge.
// Backpress: none issued; an overflowing push is dropped and an underflowing pop is flagged, both sticky, then HALT.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   umbrales_I[13:0]            thresholds {MF[1:0], VC0[3:0], VC1[3:0], D0[1:0], D1[1:0]}
//   active, idle, error         control-FSM state indications
//   push[4:0], pop[4:0]         per-FIFO strobes, bit order [0]=MF [1]=VC0 [2]=VC1 [3]=D0 [4]=D1
//   FIFO_empty, FIFO_error      to the FSM (error bits are sticky until reset)
//   almost_full, almost_empty   to the datapath
//   cfg_valid                   thresholds latched and frozen (RUN)
module fifo_status_monitor #(
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int D_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] umbrales_I,
    input  logic        active,
    input  logic        idle,
    input  logic        error,
    input  logic [4:0]  push,
    input  logic [4:0]  pop,
    output logic [4:0]  FIFO_empty,
    output logic [4:0]  FIFO_error,
    output logic [4:0]  almost_full,
    output logic [4:0]  almost_empty,
    output logic        cfg_valid
);

    localparam logic [1:0] ST_CONFIG = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALT   = 2'd2;

    localparam logic [2:0] MF_D = 3'(MF_DEPTH);
    localparam logic [4:0] VC_D = 5'(VC_DEPTH);
    localparam logic [2:0] D_D  = 3'(D_DEPTH);

    // Returns {error_event, next_count}. A push together with a pop on an
    // empty FIFO counts as an underflow but the pushed word still lands.
    function automatic logic [3:0] upd3(input logic [2:0] c, input logic [2:0] d,
                                        input logic ps, input logic pp);
        logic [2:0] n;
        logic       e;
        n = c;
        e = 1'b0;
        case ({ps, pp})
            2'b10: if (c == d) e = 1'b1; else n = c + 3'd1;
            2'b01: if (c == 3'd0) e = 1'b1; else n = c - 3'd1;
            2'b11: if (c == 3'd0) begin e = 1'b1; n = 3'd1; end
            default: ;
        endcase
        return {e, n};
    endfunction

    function automatic logic [5:0] upd5(input logic [4:0] c, input logic [4:0] d,
                                        input logic ps, input logic pp);
        logic [4:0] n;
        logic       e;
        n = c;
        e = 1'b0;
        case ({ps, pp})
            2'b10: if (c == d) e = 1'b1; else n = c + 5'd1;
            2'b01: if (c == 5'd0) e = 1'b1; else n = c - 5'd1;
            2'b11: if (c == 5'd0) begin e = 1'b1; n = 5'd1; end
            default: ;
        endcase
        return {e, n};
    endfunction

    // All operands zero-extended to 5 bits; the limit saturates at 0 so a
    // threshold at or above the depth makes almost_full permanently true.
    function automatic logic af_dec(input logic [4:0] c, input logic [4:0] d, input logic [4:0] t);
        return c >= ((t >= d) ? 5'd0 : (d - t));
    endfunction

    logic [1:0] state_q, state_d;
    logic [2:0] mf_cnt_q, mf_cnt_d, d0_cnt_q, d0_cnt_d, d1_cnt_q, d1_cnt_d;
    logic [4:0] vc0_cnt_q, vc0_cnt_d, vc1_cnt_q, vc1_cnt_d;
    logic [1:0] mf_thr_q, d0_thr_q, d1_thr_q;
    logic [3:0] vc0_thr_q, vc1_thr_q;
    logic [4:0] err_q, err_d, evt;
    logic [4:0] push_g, pop_g;
    logic       thr_load;

    // Gating the strobes in HALT both freezes the counts and suppresses new errors.
    assign push_g   = (state_q != ST_HALT) ? push : 5'd0;
    assign pop_g    = (state_q != ST_HALT) ? pop  : 5'd0;
    // The edge that sees active=1 leaves CONFIG without loading.
    assign thr_load = (state_q == ST_CONFIG) && idle && !active;

    always_comb begin
        {evt[0], mf_cnt_d}  = upd3(mf_cnt_q,  MF_D, push_g[0], pop_g[0]);
        {evt[1], vc0_cnt_d} = upd5(vc0_cnt_q, VC_D, push_g[1], pop_g[1]);
        {evt[2], vc1_cnt_d} = upd5(vc1_cnt_q, VC_D, push_g[2], pop_g[2]);
        {evt[3], d0_cnt_d}  = upd3(d0_cnt_q,  D_D,  push_g[3], pop_g[3]);
        {evt[4], d1_cnt_d}  = upd3(d1_cnt_q,  D_D,  push_g[4], pop_g[4]);
        err_d = err_q | evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mf_cnt_q  <= '0;
            vc0_cnt_q <= '0;
            vc1_cnt_q <= '0;
            d0_cnt_q  <= '0;
            d1_cnt_q  <= '0;
            mf_thr_q  <= '0;
            vc0_thr_q <= '0;
            vc1_thr_q <= '0;
            d0_thr_q  <= '0;
            d1_thr_q  <= '0;
            err_q     <= '0;
        end else begin
            mf_cnt_q  <= mf_cnt_d;
            vc0_cnt_q <= vc0_cnt_d;
            vc1_cnt_q <= vc1_cnt_d;
            d0_cnt_q  <= d0_cnt_d;
            d1_cnt_q  <= d1_cnt_d;
            err_q     <= err_d;
            if (thr_load) begin
                mf_thr_q  <= umbrales_I[13:12];
                vc0_thr_q <= umbrales_I[11:8];
                vc1_thr_q <= umbrales_I[7:4];
                d0_thr_q  <= umbrales_I[3:2];
                d1_thr_q  <= umbrales_I[1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_CONFIG;
        else        state_q <= state_d;
    end

    // Next state: a FIFO error raised on this very edge already forces HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CONFIG: begin
                if (error || (|err_d)) state_d = ST_HALT;
                else if (active)       state_d = ST_RUN;
            end
            ST_RUN: begin
                if (error || (|err_d))  state_d = ST_HALT;
                else if (!active && idle) state_d = ST_CONFIG;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_CONFIG;
        endcase
    end

    // Outputs
    always_comb begin
        cfg_valid     = (state_q == ST_RUN);
        FIFO_error    = err_q;
        FIFO_empty[0] = (mf_cnt_q  == 3'd0);
        FIFO_empty[1] = (vc0_cnt_q == 5'd0);
        FIFO_empty[2] = (vc1_cnt_q == 5'd0);
        FIFO_empty[3] = (d0_cnt_q  == 3'd0);
        FIFO_empty[4] = (d1_cnt_q  == 3'd0);
        almost_full[0] = af_dec({2'b0, mf_cnt_q},  {2'b0, MF_D}, {3'b0, mf_thr_q});
        almost_full[1] = af_dec(vc0_cnt_q,         VC_D,         {1'b0, vc0_thr_q});
        almost_full[2] = af_dec(vc1_cnt_q,         VC_D,         {1'b0, vc1_thr_q});
        almost_full[3] = af_dec({2'b0, d0_cnt_q},  {2'b0, D_D},  {3'b0, d0_thr_q});
        almost_full[4] = af_dec({2'b0, d1_cnt_q},  {2'b0, D_D},  {3'b0, d1_thr_q});
        almost_empty[0] = ({2'b0, mf_cnt_q} <= {3'b0, mf_thr_q});
        almost_empty[1] = (vc0_cnt_q        <= {1'b0, vc0_thr_q});
        almost_empty[2] = (vc1_cnt_q        <= {1'b0, vc1_thr_q});
        almost_empty[3] = ({2'b0, d0_cnt_q} <= {3'b0, d0_thr_q});
        almost_empty[4] = ({2'b0, d1_cnt_q} <= {3'b0, d1_thr_q});
    end

endmodule
